// File: rtl/digit_scan_if.sv
// digit_scan_ctrl bundle: scan enable, frame
// update strobe and display-side outputs.
interface digit_scan_if;
  logic        en;
  logic        upd;
  logic [15:0] data_in;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [15:0] disp_data;
  logic        frame_done;

  modport master (
    output en, upd, data_in,
    input  sel, an, disp_data, frame_done
  );

  modport slave (
    input  en, upd, data_in,
    output sel, an, disp_data, frame_done
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// 4-digit multiplexed display scanner with
// blanked slot start and frame-synchronous buffer.
module digit_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 4
) (
  input  logic       clk,
  input  logic       reset,
  digit_scan_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [15:0] disp;
  logic [15:0] pending;
  logic        pend;
  logic        fdone;

  assign bus.sel        = sel;
  assign bus.an         = an;
  assign bus.disp_data  = disp;
  assign bus.frame_done = fdone;

  // Scan sequencer, pending capture and frame swap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sel     <= 2'd0;
      an      <= 4'hF;
      disp    <= 16'h0;
      pending <= 16'h0;
      pend    <= 1'b0;
      fdone   <= 1'b0;
    end else begin
      fdone <= 1'b0;
      if (bus.upd) begin
        pending <= bus.data_in;
        pend    <= 1'b1;
      end
      if (!bus.en) begin
        state <= S_IDLE;
        cnt   <= '0;
        sel   <= 2'd0;
        an    <= 4'hF;
      end else begin
        unique case (state)
          S_IDLE: begin
            state <= S_BLANK;
            cnt   <= '0;
            an    <= 4'hF;
          end
          S_BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLK_LAST) begin
              state <= S_SHOW;
              an    <= ~(4'b0001 << sel);
            end
          end
          S_SHOW: begin
            if (cnt == SLOT_LAST) begin
              state <= S_BLANK;
              cnt   <= '0;
              sel   <= sel + 2'd1;
              an    <= 4'hF;
              if (sel == 2'd3) begin
                fdone <= 1'b1;
                if (bus.upd) begin
                  disp <= bus.data_in;
                  pend <= 1'b0;
                end else if (pend) begin
                  disp <= pending;
                  pend <= 1'b0;
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
            sel   <= 2'd0;
            an    <= 4'hF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: a slot/frame
// timeline model queues expected outputs per cycle.
module tb_digit_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FR    = 4 * DIV;

  typedef struct packed {
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [15:0] disp;
    logic        fd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_on  = 1'b0;

  digit_scan_if dsif ();

  digit_scan_ctrl #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dsif.slave)
  );

  always #5 clk = ~clk;

  // reference model: position in frame timeline
  exp_t        q[$];
  int          m_t    = 0;
  bit          m_run  = 1'b0;
  bit          m_pend = 1'b0;
  logic [15:0] m_pv   = 16'h0;
  logic [15:0] m_disp = 16'h0;

  function automatic exp_t cur(input bit fd);
    exp_t e;
    int   slot;
    slot   = m_run ? (m_t / DIV) : 0;
    e.sel  = 2'(slot);
    if (m_run && (m_t % DIV) >= BLANK)
      e.an = ~(4'b0001 << slot);
    else
      e.an = 4'hF;
    e.disp = m_disp;
    e.fd   = fd;
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit bnd;
    if (reset) begin
      m_t    = 0;
      m_run  = 1'b0;
      m_pend = 1'b0;
      m_pv   = 16'h0;
      m_disp = 16'h0;
      q.delete();
      q.push_back(cur(1'b0));
    end else begin
      bnd = m_run && dsif.en && (m_t == FR - 1);
      if (dsif.upd) begin
        m_pv   = dsif.data_in;
        m_pend = 1'b1;
      end
      if (bnd && m_pend) begin
        m_disp = m_pv;
        m_pend = 1'b0;
      end
      if (!dsif.en) begin
        m_run = 1'b0;
        m_t   = 0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
      end else begin
        m_t = (m_t + 1) % FR;
      end
      q.push_back(cur(bnd));
    end
  end

  // monitor: compare DUT against queued expectation
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (mon_on) begin
      n_tests++;
      a = {dsif.sel, dsif.an,
           dsif.disp_data, dsif.frame_done};
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got %h, required an expectation (queue empty)",
                 $time, a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle t=%0t: got sel=%0d an=%b disp=%h fd=%b, required sel=%0d an=%b disp=%h fd=%b",
                   $time, a.sel, a.an, a.disp, a.fd,
                   e.sel, e.an, e.disp, e.fd);
        end
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_t(input int tgt);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (m_run && m_t == tgt) hit = 1'b1;
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_t: position %0d not reached, required within 300 cycles",
               tgt);
    end
  endtask

  task automatic pulse_upd(input logic [15:0] d);
    dsif.upd     = 1'b1;
    dsif.data_in = d;
    @(negedge clk);
    dsif.upd     = 1'b0;
    dsif.data_in = 16'h0;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h",
               nm, got, req);
    end
  endtask

  initial begin
    reset        = 1'b1;
    dsif.en      = 1'b0;
    dsif.upd     = 1'b0;
    dsif.data_in = 16'h0;
    @(posedge clk);
    mon_on = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(2);

    // start scanning, three idle frames
    dsif.en = 1'b1;
    cycles(3 * FR + 4);

    // two updates in one frame: last wins
    wait_t(10);
    pulse_upd(16'h1234);
    wait_t(20);
    pulse_upd(16'h5678);
    cycles(2 * FR);

    // update exactly in the boundary cycle
    wait_t(FR - 1);
    pulse_upd(16'hABCD);
    cycles(2 * FR);

    // disable in slot 2 while lit, update while dark
    wait_t(2 * DIV + 5);
    dsif.en = 1'b0;
    cycles(2);
    pulse_upd(16'h2468);
    cycles(2);
    dsif.en = 1'b1;
    cycles(3 * FR);

    // randomized enable and update traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0)
        dsif.en = ~dsif.en;
      else if (!dsif.en && $urandom_range(0, 3) == 0)
        dsif.en = 1'b1;
      dsif.upd     = ($urandom_range(0, 9) == 0);
      dsif.data_in = 16'($urandom);
      @(negedge clk);
    end
    dsif.upd     = 1'b0;
    dsif.en      = 1'b1;
    pulse_upd(16'h9F3C);
    cycles(2 * FR);

    // asynchronous reset between edges while lit
    wait_t(DIV + 5);
    chk("pre_reset_disp", 32'(dsif.disp_data),
        32'(m_disp));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_an", 32'(dsif.an), 32'hF);
    chk("async_sel", 32'(dsif.sel), 32'h0);
    chk("async_disp", 32'(dsif.disp_data), 32'h0);
    chk("async_fd", 32'(dsif.frame_done), 32'h0);
    cycles(2);
    reset = 1'b0;
    cycles(FR + 4);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish, required finish before 600000");
    $fatal(1);
  end

endmodule
